// File: rtl/immgen_pipe.sv
// rtl/immgen_pipe.sv - registered RV immediate generator with 2-entry valid/ready skid stage
// Optional CSR zimm decode (format Z) enabled by defining IMMGEN_ZICSR_EN.
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic [31:0]      o_inst,
    output logic [TAG_W-1:0] o_tag
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMMGEN_ZICSR_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    typedef enum logic [1:0] {EMPTY, MAIN, SKID} state_t;

    state_t            state, state_nxt;
    logic              ready_q;
    logic              take, give;
    logic [31:0]       imm32;
    logic [2:0]        fmt_d;
    logic [XLEN-1:0]   imm_d;
    logic [XLEN-1:0]   head_imm, skid_imm;
    logic [2:0]        head_fmt, skid_fmt;
    logic [31:0]       head_inst, skid_inst;
    logic [TAG_W-1:0]  head_tag, skid_tag;

    // Every format is built as a 32-bit value, then sign-extended from bit 31 to XLEN.
    always_comb begin
        imm32 = '0;
        fmt_d = FMT_NONE;
        if (i_inst[1:0] == 2'b11) begin
            case (i_inst[6:2])
                5'b00000, 5'b00100, 5'b11001: begin
                    fmt_d = FMT_I;
                    imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
                end
                5'b01000: begin
                    fmt_d = FMT_S;
                    imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                end
                5'b11000: begin
                    fmt_d = FMT_B;
                    imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
                end
                5'b01101, 5'b00101: begin
                    fmt_d = FMT_U;
                    imm32 = {i_inst[31:12], 12'b0};
                end
                5'b11011: begin
                    fmt_d = FMT_J;
                    imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
                end
`ifdef IMMGEN_ZICSR_EN
                5'b11100: begin
                    if (i_inst[14]) begin
                        fmt_d = FMT_Z;
                        imm32 = {27'b0, i_inst[19:15]};
                    end
                end
`else
                5'b11100: ; // SYSTEM carries no immediate in this build
`endif
                default: ;
            endcase
        end
        imm_d = XLEN'($signed(imm32));
    end

    assign take = i_valid & ready_q;
    assign give = o_valid & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != SKID);
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (take) state_nxt = MAIN;
                MAIN: begin
                    if (take && !give)      state_nxt = SKID;
                    else if (give && !take) state_nxt = EMPTY;
                end
                SKID:    if (give) state_nxt = MAIN;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        o_valid = (state != EMPTY);
        o_ready = ready_q;
        o_imm   = head_imm;
        o_fmt   = head_fmt;
        o_inst  = head_inst;
        o_tag   = head_tag;
    end

    // Data registers hold across flush and while empty; only reset clears them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_imm  <= '0;
            head_fmt  <= '0;
            head_inst <= '0;
            head_tag  <= '0;
            skid_imm  <= '0;
            skid_fmt  <= '0;
            skid_inst <= '0;
            skid_tag  <= '0;
        end else if (!i_flush) begin
            if ((state == EMPTY && take) || (state == MAIN && take && give)) begin
                head_imm  <= imm_d;
                head_fmt  <= fmt_d;
                head_inst <= i_inst;
                head_tag  <= i_tag;
            end else if (state == MAIN && take) begin
                skid_imm  <= imm_d;
                skid_fmt  <= fmt_d;
                skid_inst <= i_inst;
                skid_tag  <= i_tag;
            end else if (state == SKID && give) begin
                head_imm  <= skid_imm;
                head_fmt  <= skid_fmt;
                head_inst <= skid_inst;
                head_tag  <= skid_tag;
            end
        end
    end

endmodule

// File: tb/tb_immgen_pipe.sv
// tb/tb_immgen_pipe.sv - directed and random checks of immgen_pipe at XLEN 32 and 64
module tb_immgen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, valid, ready;
    logic [31:0] inst, tag;

    logic        v32, r32, v64, r64;
    logic [31:0] imm32_o, inst32_o, tag32_o, inst64_o, tag64_o;
    logic [63:0] imm64_o;
    logic [2:0]  fmt32_o, fmt64_o;

    always #5 clk = ~clk;

    immgen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(r32),
        .i_inst(inst), .i_tag(tag), .o_valid(v32), .i_ready(ready),
        .o_imm(imm32_o), .o_fmt(fmt32_o), .o_inst(inst32_o), .o_tag(tag32_o));

    immgen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(r64),
        .i_inst(inst), .i_tag(tag), .o_valid(v64), .i_ready(ready),
        .o_imm(imm64_o), .o_fmt(fmt64_o), .o_inst(inst64_o), .o_tag(tag64_o));

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] inst;
        logic [31:0] tag;
    } ent_t;

    ent_t q[$];
    ent_t shown;
    int   total = 0;
    int   bad = 0;

    // Reference decode with plain arithmetic: field value minus 2^width when negative.
    function automatic ent_t mk(input logic [31:0] ins, input logic [31:0] tg);
        ent_t   e;
        longint v;
        int     f;
        v = 0;
        f = 0;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:2])
                5'b00000, 5'b00100, 5'b11001: begin
                    f = 1; v = ins[31:20];
                    if (ins[31]) v = v - 4096;
                end
                5'b01000: begin
                    f = 2; v = {ins[31:25], ins[11:7]};
                    if (ins[31]) v = v - 4096;
                end
                5'b11000: begin
                    f = 3; v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                    if (ins[31]) v = v - 8192;
                end
                5'b01101, 5'b00101: begin
                    f = 4; v = longint'(ins[31:12]) * 4096;
                    if (ins[31]) v = v - 64'sh1_0000_0000;
                end
                5'b11011: begin
                    f = 5; v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                    if (ins[31]) v = v - 2097152;
                end
`ifdef IMMGEN_ZICSR_EN
                5'b11100: if (ins[14]) begin f = 6; v = ins[19:15]; end
`endif
                default: ;
            endcase
        end
        e.imm  = v;
        e.fmt  = 3'(f);
        e.inst = ins;
        e.tag  = tg;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic model_update();
        bit acc, out;
        if (rst) begin
            q.delete();
            shown = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = valid && (q.size() < 2);
            out = ready && (q.size() > 0);
            if (out) void'(q.pop_front());
            if (acc) q.push_back(mk(inst, tag));
        end
        if (q.size() > 0) shown = q[0];
    endtask

    task automatic check_all();
        chk("valid32", 64'(v32), 64'(q.size() > 0));
        chk("valid64", 64'(v64), 64'(q.size() > 0));
        chk("ready32", 64'(r32), 64'(q.size() < 2));
        chk("ready64", 64'(r64), 64'(q.size() < 2));
        chk("imm32",   64'(imm32_o), 64'(shown.imm[31:0]));
        chk("imm64",   imm64_o, shown.imm);
        chk("fmt32",   64'(fmt32_o), 64'(shown.fmt));
        chk("fmt64",   64'(fmt64_o), 64'(shown.fmt));
        chk("inst",    64'(inst32_o), 64'(shown.inst));
        chk("inst64",  64'(inst64_o), 64'(shown.inst));
        chk("tag",     64'(tag32_o), 64'(shown.tag));
        chk("tag64",   64'(tag64_o), 64'(shown.tag));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    logic [4:0] ops [12] = '{5'b00000, 5'b00100, 5'b11001, 5'b01000, 5'b11000, 5'b01101,
                             5'b00101, 5'b11011, 5'b11100, 5'b01100, 5'b00011, 5'b11111};

    initial begin
        shown = '0;
        rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0; inst = '0; tag = '0;
        tick();
        tick();
        chk("rst_valid", 64'(v32), 64'd0);
        chk("rst_ready", 64'(r32), 64'd1);
        chk("rst_imm",   imm64_o, 64'd0);

        // addi x1,x0,-1
        rst = 1'b0; ready = 1'b1; valid = 1'b1; inst = 32'hFFF00093; tag = 32'h11;
        tick();
        chk("t1_valid", 64'(v32), 64'd1);
        chk("t1_imm",   64'(imm32_o), 64'hFFFF_FFFF);
        chk("t1_fmt",   64'(fmt32_o), 64'd1);

        inst = 32'hFE000EE3; tag = 32'h12;
        tick();
        chk("t2_beq_imm", 64'(imm32_o), 64'hFFFF_FFFC);
        chk("t2_beq_fmt", 64'(fmt32_o), 64'd3);
        inst = 32'h800000B7; tag = 32'h13;
        tick();
        chk("t2_lui_imm64", imm64_o, 64'hFFFF_FFFF_8000_0000);
        chk("t2_lui_fmt",   64'(fmt64_o), 64'd4);
        valid = 1'b0;
        tick();

        // back-pressure: third tag must wait upstream
        ready = 1'b0; valid = 1'b1; inst = 32'h00100093;
        tag = 32'd1; tick();
        tag = 32'd2; tick();
        chk("t3_ready_low", 64'(r32), 64'd0);
        tag = 32'd3; tick();
        chk("t3_head1", 64'(tag32_o), 64'd1);
        ready = 1'b1;
        tick();
        chk("t3_head2", 64'(tag32_o), 64'd2);
        tick();
        chk("t3_head3", 64'(tag32_o), 64'd3);
        valid = 1'b0;
        tick();
        chk("t3_drained", 64'(v32), 64'd0);

        // flush while in SKID with a same-cycle input
        ready = 1'b0; valid = 1'b1;
        tag = 32'd21; tick();
        tag = 32'd22; tick();
        flush = 1'b1; tag = 32'd23; tick();
        chk("t4_valid", 64'(v32), 64'd0);
        chk("t4_ready", 64'(r32), 64'd1);
        flush = 1'b0; valid = 1'b0; ready = 1'b1;
        tick();
        chk("t4_still_empty", 64'(v64), 64'd0);

        // reset while in SKID, then 1-cycle latency
        ready = 1'b0; valid = 1'b1;
        tag = 32'd31; tick();
        tag = 32'd32; tick();
        rst = 1'b1; tick();
        chk("t5_valid", 64'(v32), 64'd0);
        chk("t5_ready", 64'(r32), 64'd1);
        chk("t5_tag",   64'(tag32_o), 64'd0);
        chk("t5_inst",  64'(inst64_o), 64'd0);
        rst = 1'b0; ready = 1'b1; inst = 32'h800000B7; tag = 32'd33;
        tick();
        chk("t5_latency", 64'(v32), 64'd1);
        chk("t5_imm32",   64'(imm32_o), 64'h8000_0000);

        // csrrwi
        inst = 32'h300FD073; tag = 32'd41;
        tick();
`ifdef IMMGEN_ZICSR_EN
        chk("t6_imm", 64'(imm32_o), 64'h1F);
        chk("t6_fmt", 64'(fmt32_o), 64'd6);
`else
        chk("t6_imm", 64'(imm32_o), 64'd0);
        chk("t6_fmt", 64'(fmt32_o), 64'd0);
`endif
        valid = 1'b0;
        tick();

        for (int i = 0; i < 600; i++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:2] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) != 0) w[1:0] = 2'b11;
            inst  = w;
            tag   = $urandom;
            valid = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
